wb_stage_pipelined: RTL and testbench

//  Registered write-back stage for the 16-bit pipeline; successor to the single 2:1 MemtoReg mux.

---
 rtl/wb_pkg.sv | 17 +
 rtl/load_align.sv | 24 ++
 rtl/wb_stage_pipelined.sv | 166 ++++++++++++++++
 tb/tb_wb_stage_pipelined.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared encodings for the write-back stage.
package wb_pkg;

    typedef enum logic [1:0] {
        SRC_ALU  = 2'd0,
        SRC_MEM  = 2'd1,
        SRC_LINK = 2'd2,
        SRC_IMM  = 2'd3
    } src_sel_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MEM = 2'd1,
        DRAIN    = 2'd2
    } wb_state_e;

endpackage

// File: rtl/load_align.sv
// Sub-word load alignment: picks a byte lane and sign/zero extends it.
module load_align #(
    parameter int DATA_W = 16,
    localparam int BS_W  = $clog2(DATA_W / 8)
) (
    input  logic [DATA_W-1:0] rdata_i,
    input  logic              byte_i,
    input  logic              signed_i,
    input  logic [BS_W-1:0]   byte_sel_i,
    output logic [DATA_W-1:0] data_o
);

    logic [7:0] lane;

    assign lane = 8'(rdata_i >> {byte_sel_i, 3'b000});

    always_comb begin
        data_o = rdata_i;
        if (byte_i) begin
            data_o = {{(DATA_W - 8){signed_i & lane[7]}}, lane};
        end
    end

endmodule

// File: rtl/wb_stage_pipelined.sv
// Registered write-back stage: source select, load alignment, memory wait,
// register-file write port and retired-instruction counter.
module wb_stage_pipelined
    import wb_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 3,
    parameter int RETIRE_W   = 16,
    parameter int ZERO_REG   = 1,
    localparam int BS_W      = $clog2(DATA_W / 8)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_reg_write,
    input  logic [REG_ADDR_W-1:0] in_dest,
    input  logic [1:0]            in_src_sel,
    input  logic [DATA_W-1:0]     in_alu_result,
    input  logic [DATA_W-1:0]     in_link,
    input  logic [DATA_W-1:0]     in_imm,
    input  logic                  in_load_byte,
    input  logic                  in_load_signed,
    input  logic [BS_W-1:0]       in_byte_sel,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_rvalid,
    input  logic                  flush,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0]     rf_wdata,
    output logic [RETIRE_W-1:0]   retire_count
);

    wb_state_e state_q, state_d;

    logic                  hold_we_q;
    logic [REG_ADDR_W-1:0] hold_dest_q;
    logic                  hold_lb_q;
    logic                  hold_ls_q;
    logic [BS_W-1:0]       hold_bs_q;

    logic                  rf_we_q;
    logic [REG_ADDR_W-1:0] rf_waddr_q;
    logic [DATA_W-1:0]     rf_wdata_q;
    logic [RETIRE_W-1:0]   retire_q;

    logic                  idle;
    logic                  commit;
    logic                  latch;
    logic                  c_we;
    logic [REG_ADDR_W-1:0] c_dest;
    logic [DATA_W-1:0]     c_data;
    logic                  dest_zero;
    logic                  al_byte;
    logic                  al_signed;
    logic [BS_W-1:0]       al_sel;
    logic [DATA_W-1:0]     aligned;

    assign idle     = (state_q == IDLE);
    assign in_ready = idle;

    // A same-cycle load aligns with live fields; a waited load with held ones.
    assign al_byte   = idle ? in_load_byte   : hold_lb_q;
    assign al_signed = idle ? in_load_signed : hold_ls_q;
    assign al_sel    = idle ? in_byte_sel    : hold_bs_q;

    load_align #(
        .DATA_W(DATA_W)
    ) u_align (
        .rdata_i   (mem_rdata),
        .byte_i    (al_byte),
        .signed_i  (al_signed),
        .byte_sel_i(al_sel),
        .data_o    (aligned)
    );

    always_comb begin
        state_d = state_q;
        commit  = 1'b0;
        latch   = 1'b0;
        c_we    = in_reg_write;
        c_dest  = in_dest;
        c_data  = in_alu_result;
        unique case (state_q)
            IDLE: begin
                unique case (src_sel_e'(in_src_sel))
                    SRC_ALU:  c_data = in_alu_result;
                    SRC_MEM:  c_data = aligned;
                    SRC_LINK: c_data = in_link;
                    SRC_IMM:  c_data = in_imm;
                endcase
                if (in_valid && !flush) begin
                    if (in_src_sel != SRC_MEM || mem_rvalid) begin
                        commit = 1'b1;
                    end else begin
                        latch   = 1'b1;
                        state_d = WAIT_MEM;
                    end
                end
            end
            WAIT_MEM: begin
                c_we   = hold_we_q;
                c_dest = hold_dest_q;
                c_data = aligned;
                if (mem_rvalid) begin
                    state_d = IDLE;
                    commit  = !flush;
                end else if (flush) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (mem_rvalid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign dest_zero = (ZERO_REG != 0) && (c_dest == '0);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            hold_we_q   <= 1'b0;
            hold_dest_q <= '0;
            hold_lb_q   <= 1'b0;
            hold_ls_q   <= 1'b0;
            hold_bs_q   <= '0;
            rf_we_q     <= 1'b0;
            rf_waddr_q  <= '0;
            rf_wdata_q  <= '0;
            retire_q    <= '0;
        end else begin
            state_q <= state_d;
            if (latch) begin
                hold_we_q   <= in_reg_write;
                hold_dest_q <= in_dest;
                hold_lb_q   <= in_load_byte;
                hold_ls_q   <= in_load_signed;
                hold_bs_q   <= in_byte_sel;
            end
            rf_we_q <= commit && c_we && !dest_zero;
            if (commit) begin
                rf_waddr_q <= c_dest;
                rf_wdata_q <= c_data;
                retire_q   <= retire_q + RETIRE_W'(1);
            end
        end
    end

    assign rf_we        = rf_we_q;
    assign rf_waddr     = rf_waddr_q;
    assign rf_wdata     = rf_wdata_q;
    assign retire_count = retire_q;

`ifndef SYNTHESIS
    // Memory must not answer while idle unless a load is being accepted.
    a_stray_rvalid: assert property (
        @(posedge clock) disable iff (!reset_n)
        (idle && mem_rvalid) |-> (in_valid && in_src_sel == SRC_MEM)
    ) else $error("stray mem_rvalid while idle");
`endif

endmodule

// File: tb/tb_wb_stage_pipelined.sv
// Scoreboard bench for wb_stage_pipelined (RETIRE_W=4 to exercise wrap).
module tb_wb_stage_pipelined;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_reg_write;
    logic [2:0]  in_dest;
    logic [1:0]  in_src_sel;
    logic [15:0] in_alu_result;
    logic [15:0] in_link;
    logic [15:0] in_imm;
    logic        in_load_byte;
    logic        in_load_signed;
    logic [0:0]  in_byte_sel;
    logic [15:0] mem_rdata;
    logic        mem_rvalid;
    logic        flush;
    logic        rf_we;
    logic [2:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic [3:0]  retire_count;

    always #5 clk = ~clk;

    wb_stage_pipelined #(
        .DATA_W(16), .REG_ADDR_W(3), .RETIRE_W(4), .ZERO_REG(1)
    ) dut (
        .clock(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_reg_write(in_reg_write), .in_dest(in_dest),
        .in_src_sel(in_src_sel), .in_alu_result(in_alu_result),
        .in_link(in_link), .in_imm(in_imm),
        .in_load_byte(in_load_byte), .in_load_signed(in_load_signed),
        .in_byte_sel(in_byte_sel), .mem_rdata(mem_rdata),
        .mem_rvalid(mem_rvalid), .flush(flush),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .retire_count(retire_count)
    );

    typedef struct {
        logic [2:0]  a;
        logic [15:0] d;
        logic [3:0]  c;
    } exp_t;

    exp_t       q[$];
    int         total  = 0;
    int         passed = 0;
    logic [3:0] cnt    = 4'd0;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic idle();
        in_valid   = 1'b0;
        mem_rvalid = 1'b0;
        flush      = 1'b0;
    endtask

    // Entered and left at a negedge; the accept edge lies in between.
    task automatic issue(input logic [1:0] src, input logic [2:0] dest,
                         input logic rw, input logic [15:0] v,
                         input logic lb, input logic ls, input logic bs,
                         input logic rv, input logic [15:0] rd,
                         input logic [15:0] exp, input logic fl);
        in_valid       = 1'b1;
        in_src_sel     = src;
        in_dest        = dest;
        in_reg_write   = rw;
        in_alu_result  = (src == 2'd0) ? v : 16'hA1A1;
        in_link        = (src == 2'd2) ? v : 16'hB2B2;
        in_imm         = (src == 2'd3) ? v : 16'hC3C3;
        in_load_byte   = lb;
        in_load_signed = ls;
        in_byte_sel    = bs;
        mem_rvalid     = rv;
        mem_rdata      = rd;
        flush          = fl;
        if (!fl && (src != 2'd1 || rv)) begin
            cnt++;
            if (rw && dest != 3'd0) q.push_back('{dest, exp, cnt});
        end
        @(negedge clk);
        idle();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rf_we === 1'b1) begin
                if (q.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_write: got addr %h data %h expected none",
                             rf_waddr, rf_wdata);
                end else begin
                    e = q.pop_front();
                    check("waddr", 32'(rf_waddr), 32'(e.a));
                    check("wdata", 32'(rf_wdata), 32'(e.d));
                    check("count", 32'(retire_count), 32'(e.c));
                end
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        idle();
        in_reg_write = 0; in_dest = 0; in_src_sel = 0;
        in_alu_result = 0; in_link = 0; in_imm = 0;
        in_load_byte = 0; in_load_signed = 0; in_byte_sel = 0;
        mem_rdata = 0;
        repeat (2) @(negedge clk);
        check("rst_we", 32'(rf_we), 0);
        check("rst_waddr", 32'(rf_waddr), 0);
        check("rst_wdata", 32'(rf_wdata), 0);
        check("rst_count", 32'(retire_count), 0);
        check("rst_ready", 32'(in_ready), 1);
        reset_n = 1'b1;
        @(negedge clk);

        // Plain sources
        issue(2'd0, 3'd3, 1, 16'h1234, 0, 0, 0, 0, 16'h0, 16'h1234, 0);
        check("alu_count", 32'(retire_count), 1);
        issue(2'd2, 3'd5, 1, 16'h0042, 0, 0, 0, 0, 16'h0, 16'h0042, 0);
        issue(2'd3, 3'd6, 1, 16'h7777, 0, 0, 0, 0, 16'h0, 16'h7777, 0);
        issue(2'd1, 3'd1, 1, 16'h0, 0, 1, 1, 1, 16'hCAFE, 16'hCAFE, 0);
        issue(2'd0, 3'd2, 1, 16'h80F0, 1, 1, 1, 0, 16'h0, 16'h80F0, 0);

        // Byte loads, same-cycle data
        issue(2'd1, 3'd4, 1, 16'h0, 1, 1, 1, 1, 16'h80F0, 16'hFF80, 0);
        issue(2'd1, 3'd4, 1, 16'h0, 1, 0, 1, 1, 16'h80F0, 16'h0080, 0);
        issue(2'd1, 3'd4, 1, 16'h0, 1, 1, 0, 1, 16'h80F0, 16'hFFF0, 0);
        issue(2'd1, 3'd4, 1, 16'h0, 1, 0, 0, 1, 16'h80F0, 16'h00F0, 0);

        // Load wait, live fields scrambled while waiting
        issue(2'd1, 3'd2, 1, 16'h0, 0, 0, 0, 0, 16'h0, 16'h0, 0);
        in_dest = 3'd7; in_src_sel = 2'd0; in_load_byte = 1;
        check("wait_ready1", 32'(in_ready), 0);
        @(negedge clk);
        check("wait_ready2", 32'(in_ready), 0);
        @(negedge clk);
        check("wait_ready3", 32'(in_ready), 0);
        mem_rvalid = 1'b1; mem_rdata = 16'hBEEF;
        cnt++; q.push_back('{3'd2, 16'hBEEF, cnt});
        @(negedge clk);
        idle();
        check("load_latency", 32'(rf_we), 1);
        check("load_ready", 32'(in_ready), 1);

        // Byte load through the wait path uses held lane/sign
        issue(2'd1, 3'd5, 1, 16'h0, 1, 1, 1, 0, 16'h0, 16'h0, 0);
        in_load_byte = 0; in_load_signed = 0; in_byte_sel = 0; in_dest = 3'd1;
        @(negedge clk);
        mem_rvalid = 1'b1; mem_rdata = 16'h85AA;
        cnt++; q.push_back('{3'd5, 16'hFF85, cnt});
        @(negedge clk);
        idle();

        // Zero register and no-write commits still retire
        issue(2'd3, 3'd0, 1, 16'h0005, 0, 0, 0, 0, 16'h0, 16'h0005, 0);
        check("zero_we", 32'(rf_we), 0);
        check("zero_count", 32'(retire_count), 32'(cnt));
        issue(2'd0, 3'd3, 0, 16'h4444, 0, 0, 0, 0, 16'h0, 16'h4444, 0);
        check("nowrite_we", 32'(rf_we), 0);
        check("nowrite_count", 32'(retire_count), 32'(cnt));

        // Flush in WAIT_MEM, then response drained
        issue(2'd1, 3'd3, 1, 16'h0, 0, 0, 0, 0, 16'h0, 16'h0, 0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("drain_ready", 32'(in_ready), 0);
        @(negedge clk);
        mem_rvalid = 1'b1; mem_rdata = 16'hDEAD;
        @(negedge clk);
        idle();
        check("drain_we", 32'(rf_we), 0);
        check("drain_count", 32'(retire_count), 32'(cnt));
        check("drain_ready_after", 32'(in_ready), 1);

        // Flush in WAIT_MEM coinciding with the response
        issue(2'd1, 3'd6, 1, 16'h0, 0, 0, 0, 0, 16'h0, 16'h0, 0);
        flush = 1'b1; mem_rvalid = 1'b1; mem_rdata = 16'h1357;
        @(negedge clk);
        idle();
        check("flushrv_we", 32'(rf_we), 0);
        check("flushrv_ready", 32'(in_ready), 1);

        // Flush in IDLE drops the accepted instruction
        issue(2'd0, 3'd1, 1, 16'h9999, 0, 0, 0, 0, 16'h0, 16'h9999, 1);
        check("flushidle_we", 32'(rf_we), 0);
        issue(2'd1, 3'd1, 1, 16'h0, 0, 0, 0, 1, 16'h2468, 16'h2468, 1);
        check("flushidle_count", 32'(retire_count), 32'(cnt));

        // Wrap: 17 commits from reset leave the 4-bit counter at 1
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        cnt = 4'd0;
        for (int i = 0; i < 17; i++) begin
            issue(2'd0, 3'd5, 1, 16'h0100 + 16'(i), 0, 0, 0, 0,
                  16'h0, 16'h0100 + 16'(i), 0);
        end
        check("wrap_count", 32'(retire_count), 1);

        // Reset while waiting on memory
        issue(2'd1, 3'd4, 1, 16'h0, 0, 0, 0, 0, 16'h0, 16'h0, 0);
        check("prerst_ready", 32'(in_ready), 0);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        cnt = 4'd0;
        check("midrst_ready", 32'(in_ready), 1);
        check("midrst_we", 32'(rf_we), 0);
        check("midrst_waddr", 32'(rf_waddr), 0);
        check("midrst_wdata", 32'(rf_wdata), 0);
        check("midrst_count", 32'(retire_count), 0);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(q.size()), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
